// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Purpose  : Two-read / two-write register file with same-cycle write
//             bypass, optional hardwired zero register and a per-register
//             pending scoreboard for multi-cycle loads.
//  Revision : 1.0
// ============================================================================
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2,
    input  logic              WreA,
    input  logic [ADDR_W-1:0] WAddrA,
    input  logic [DATA_W-1:0] WDataA,
    input  logic              WreB,
    input  logic [ADDR_W-1:0] WAddrB,
    input  logic [DATA_W-1:0] WDataB,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueDst,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Stall,
    output logic [ADDR_W:0]   PendCount
);

    localparam int   c_DEPTH = 2 ** ADDR_W;
    localparam logic c_ZERO  = (ZERO_REG != 0);
    localparam logic c_BYP   = (BYPASS != 0);

    logic [DATA_W-1:0]  r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;
    logic [ADDR_W:0]    r_pcnt;

    logic               w_wen_a;
    logic               w_wen_b;
    logic               w_issue;
    logic [c_DEPTH-1:0] w_pend_nxt;
    logic [ADDR_W:0]    w_pcnt_nxt;
    logic [DATA_W-1:0]  w_rd1;
    logic [DATA_W-1:0]  w_rd2;
    logic               w_res1;
    logic               w_res2;
    logic               w_res_issue;

    // Address 0 is a sink for writes and issues when the zero register is on.
    assign w_wen_a = WreA && !(c_ZERO && (WAddrA == '0));
    assign w_wen_b = WreB && !(c_ZERO && (WAddrB == '0));
    assign w_issue = IssueValid && !(c_ZERO && (IssueDst == '0));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wen_a) r_regs[WAddrA] <= WDataA;
            // Later assignment wins, so the load port owns a collision.
            if (w_wen_b) r_regs[WAddrB] <= WDataB;
        end
    end

    always_comb begin
        w_pend_nxt = r_pend;
        if (WreB)    w_pend_nxt[WAddrB]   = 1'b0;
        if (w_issue) w_pend_nxt[IssueDst] = 1'b1;
        w_pcnt_nxt = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_pcnt_nxt = w_pcnt_nxt + (ADDR_W+1)'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pend <= '0;
            r_pcnt <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_pcnt <= w_pcnt_nxt;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            always_comb begin
                w_rd1 = r_regs[rs];
                if (WreA && (WAddrA == rs)) w_rd1 = WDataA;
                if (WreB && (WAddrB == rs)) w_rd1 = WDataB;
                w_rd2 = r_regs[rt];
                if (WreA && (WAddrA == rt)) w_rd2 = WDataA;
                if (WreB && (WAddrB == rt)) w_rd2 = WDataB;
            end
        end else begin : g_no_bypass
            assign w_rd1 = r_regs[rs];
            assign w_rd2 = r_regs[rt];
        end
    endgenerate

    assign Data1 = (c_ZERO && (rs == '0)) ? '0 : w_rd1;
    assign Data2 = (c_ZERO && (rt == '0)) ? '0 : w_rd2;

    assign w_res1      = WreB && (WAddrB == rs);
    assign w_res2      = WreB && (WAddrB == rt);
    assign w_res_issue = WreB && (WAddrB == IssueDst);

    // Without bypass the resolving value is not yet visible, so stay busy.
    assign Busy1 = r_pend[rs] && !(c_BYP && w_res1);
    assign Busy2 = r_pend[rt] && !(c_BYP && w_res2);
    assign Stall = Busy1 || Busy2 || (IssueValid && r_pend[IssueDst] && !w_res_issue);

    assign PendCount = r_pcnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp_sb
//  Purpose  : Self-checking bench for regfile_mp_sb, bypass and no-bypass
//             builds side by side against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_regfile_mp_sb;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [4:0]  rs, rt, WAddrA, WAddrB, IssueDst;
    logic [31:0] WDataA, WDataB;
    logic        WreA, WreB, IssueValid;

    logic [31:0] d1_b, d2_b, d1_n, d2_n;
    logic        b1_b, b2_b, st_b, b1_n, b2_n, st_n;
    logic [5:0]  pc_b, pc_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    always #5 CLK = ~CLK;

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .CLK(CLK), .Reset(Reset), .rs(rs), .rt(rt), .Data1(d1_b), .Data2(d2_b),
        .WreA(WreA), .WAddrA(WAddrA), .WDataA(WDataA),
        .WreB(WreB), .WAddrB(WAddrB), .WDataB(WDataB),
        .IssueValid(IssueValid), .IssueDst(IssueDst),
        .Busy1(b1_b), .Busy2(b2_b), .Stall(st_b), .PendCount(pc_b));

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nob (
        .CLK(CLK), .Reset(Reset), .rs(rs), .rt(rt), .Data1(d1_n), .Data2(d2_n),
        .WreA(WreA), .WAddrA(WAddrA), .WDataA(WDataA),
        .WreB(WreB), .WAddrB(WAddrB), .WDataB(WDataB),
        .IssueValid(IssueValid), .IssueDst(IssueDst),
        .Busy1(b1_n), .Busy2(b2_n), .Stall(st_n), .PendCount(pc_n));

    // Reference model: what a reader sees given the architectural state.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && WreB && WAddrB == a) return WDataB;
        if (byp && WreA && WAddrA == a) return WDataA;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a, input bit byp);
        return m_pend[a] && !(byp && WreB && WAddrB == a);
    endfunction

    function automatic bit exp_stall(input bit byp);
        return exp_busy(rs, byp) || exp_busy(rt, byp) ||
               (IssueValid && m_pend[IssueDst] && !(WreB && WAddrB == IssueDst));
    endfunction

    function automatic logic [5:0] exp_cnt();
        int n = 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return 6'(n);
    endfunction

    task automatic idle();
        Reset = 0; WreA = 0; WreB = 0; IssueValid = 0;
        WAddrA = 0; WAddrB = 0; WDataA = 0; WDataB = 0; IssueDst = 0;
    endtask

    // One clock edge; the model commits the same edge's inputs.
    task automatic tick();
        @(posedge CLK);
        if (Reset) begin
            foreach (m_regs[i]) begin m_regs[i] = 0; m_pend[i] = 0; end
        end else begin
            if (WreA && WAddrA != 0) m_regs[WAddrA] = WDataA;
            if (WreB && WAddrB != 0) m_regs[WAddrB] = WDataB;
            if (WreB) m_pend[WAddrB] = 0;
            if (IssueValid && IssueDst != 0) m_pend[IssueDst] = 1;
        end
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle(); Reset = 1; tick();
        rs = 0; rt = 1; #2;
        total += 3;
        if (d1_b !== 0 || d1_n !== 0) begin bad++; $display("FAIL reset_d1 got %h/%h want 0", d1_b, d1_n); end
        if (d2_b !== 0 || d2_n !== 0) begin bad++; $display("FAIL reset_d2 got %h/%h want 0", d2_b, d2_n); end
        if (pc_b !== 0 || pc_n !== 0) begin bad++; $display("FAIL reset_cnt got %0d/%0d want 0", pc_b, pc_n); end
        WreA = 1; WAddrA = 2; WDataA = 1; tick();
        rs = 2; #2;
        total++;
        if (d1_b !== 1 || d1_n !== 1) begin bad++; $display("FAIL write_r2 got %h/%h want 1", d1_b, d1_n); end
    endtask

    task automatic test_zero();
        WreA = 1; WAddrA = 0; WDataA = 32'hFFFF_FFFF;
        WreB = 1; WAddrB = 0; WDataB = 32'h1234_5678;
        rs = 0; #2;
        total++;
        if (d1_b !== 0 || d1_n !== 0) begin bad++; $display("FAIL zero_same got %h/%h want 0", d1_b, d1_n); end
        tick();
        rs = 0; #2;
        total++;
        if (d1_b !== 0 || d1_n !== 0) begin bad++; $display("FAIL zero_after got %h/%h want 0", d1_b, d1_n); end
        IssueValid = 1; IssueDst = 0; rt = 0; #2;
        total++;
        if (st_b !== 0 || st_n !== 0) begin bad++; $display("FAIL zero_stall got %b/%b want 0", st_b, st_n); end
        tick();
        #2;
        total++;
        if (pc_b !== 0 || pc_n !== 0) begin bad++; $display("FAIL zero_cnt got %0d/%0d want 0", pc_b, pc_n); end
    endtask

    task automatic test_collision();
        WreA = 1; WAddrA = 5; WDataA = 3;
        WreB = 1; WAddrB = 5; WDataB = 4;
        rs = 5; #2;
        total += 2;
        if (d1_b !== 4) begin bad++; $display("FAIL coll_byp got %h want 4", d1_b); end
        if (d1_n !== 0) begin bad++; $display("FAIL coll_nob got %h want 0", d1_n); end
        tick();
        rs = 5; #2;
        total++;
        if (d1_b !== 4 || d1_n !== 4) begin bad++; $display("FAIL coll_after got %h/%h want 4", d1_b, d1_n); end
    endtask

    task automatic test_scoreboard();
        IssueValid = 1; IssueDst = 4; tick();
        rt = 4; rs = 1; #2;
        total += 3;
        if (b2_b !== 1 || b2_n !== 1) begin bad++; $display("FAIL sb_busy got %b/%b want 1", b2_b, b2_n); end
        if (st_b !== 1 || st_n !== 1) begin bad++; $display("FAIL sb_stall got %b/%b want 1", st_b, st_n); end
        if (pc_b !== 1 || pc_n !== 1) begin bad++; $display("FAIL sb_cnt got %0d/%0d want 1", pc_b, pc_n); end
        WreB = 1; WAddrB = 4; WDataB = 7; #2;
        total += 3;
        if (b2_b !== 0 || d2_b !== 7) begin bad++; $display("FAIL sb_res_byp got busy=%b data=%h want 0/7", b2_b, d2_b); end
        if (b2_n !== 1 || st_n !== 1) begin bad++; $display("FAIL sb_res_nob got busy=%b stall=%b want 1/1", b2_n, st_n); end
        if (st_b !== 0) begin bad++; $display("FAIL sb_res_stall got %b want 0", st_b); end
        tick();
        rt = 4; #2;
        total++;
        if (pc_b !== 0 || pc_n !== 0 || d2_n !== 7) begin bad++; $display("FAIL sb_clear got cnt=%0d/%0d d2=%h want 0/0/7", pc_b, pc_n, d2_n); end
    endtask

    task automatic test_set_clear();
        IssueValid = 1; IssueDst = 6; WreB = 1; WAddrB = 6; WDataB = 9; tick();
        rs = 6; rt = 0; #2;
        total += 2;
        if (pc_b !== 1 || pc_n !== 1) begin bad++; $display("FAIL setclr_cnt got %0d/%0d want 1", pc_b, pc_n); end
        if (b1_b !== 1 || b1_n !== 1) begin bad++; $display("FAIL setclr_busy got %b/%b want 1", b1_b, b1_n); end
        rs = 1; rt = 1; IssueValid = 1; IssueDst = 6; #2;
        total++;
        if (st_b !== 1 || st_n !== 1) begin bad++; $display("FAIL waw_stall got %b/%b want 1", st_b, st_n); end
        tick();
        #2;
        total++;
        if (pc_b !== 1 || pc_n !== 1) begin bad++; $display("FAIL waw_cnt got %0d/%0d want 1", pc_b, pc_n); end
        IssueValid = 1; IssueDst = 7; WreB = 1; WAddrB = 6; WDataB = 2; tick();
        #2;
        total++;
        if (pc_b !== 1 || pc_n !== 1) begin bad++; $display("FAIL swap_cnt got %0d/%0d want 1", pc_b, pc_n); end
        WreB = 1; WAddrB = 7; WDataB = 5; tick();
    endtask

    task automatic test_reset_midload();
        IssueValid = 1; IssueDst = 3; tick();
        IssueValid = 1; IssueDst = 9; tick();
        #2;
        total++;
        if (pc_b !== 2 || pc_n !== 2) begin bad++; $display("FAIL mid_cnt got %0d/%0d want 2", pc_b, pc_n); end
        Reset = 1; tick();
        rs = 3; rt = 9; #2;
        total += 3;
        if (pc_b !== 0 || pc_n !== 0) begin bad++; $display("FAIL mid_rst_cnt got %0d/%0d want 0", pc_b, pc_n); end
        if (b1_b || b2_b || b1_n || b2_n) begin bad++; $display("FAIL mid_rst_busy got %b%b/%b%b want 00", b1_b, b2_b, b1_n, b2_n); end
        rs = 2; rt = 5; #1;
        if (d1_b !== 0 || d2_b !== 0 || d1_n !== 0 || d2_n !== 0) begin bad++; $display("FAIL mid_rst_data got %h %h want 0", d1_b, d2_b); end
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rs = rnd_addr(); rt = rnd_addr();
            WreA = 1'($urandom_range(0, 1)); WAddrA = rnd_addr(); WDataA = $urandom;
            WreB = ($urandom_range(0, 2) == 0); WAddrB = rnd_addr(); WDataB = $urandom;
            IssueValid = ($urandom_range(0, 2) == 0); IssueDst = rnd_addr();
            Reset = ($urandom_range(0, 80) == 0);
            #2;
            for (int k = 0; k < 2; k++) begin
                bit byp;
                logic [31:0] a1, a2;
                logic ab1, ab2, ast;
                logic [5:0] apc;
                byp = (k == 0);
                a1  = byp ? d1_b : d1_n;  a2  = byp ? d2_b : d2_n;
                ab1 = byp ? b1_b : b1_n;  ab2 = byp ? b2_b : b2_n;
                ast = byp ? st_b : st_n;  apc = byp ? pc_b : pc_n;
                total += 6;
                if (a1 !== exp_rd(rs, byp)) begin bad++; $display("FAIL rnd_d1 byp=%0d cyc=%0d got %h want %h", byp, c, a1, exp_rd(rs, byp)); end
                if (a2 !== exp_rd(rt, byp)) begin bad++; $display("FAIL rnd_d2 byp=%0d cyc=%0d got %h want %h", byp, c, a2, exp_rd(rt, byp)); end
                if (ab1 !== exp_busy(rs, byp)) begin bad++; $display("FAIL rnd_busy1 byp=%0d cyc=%0d got %b want %b", byp, c, ab1, exp_busy(rs, byp)); end
                if (ab2 !== exp_busy(rt, byp)) begin bad++; $display("FAIL rnd_busy2 byp=%0d cyc=%0d got %b want %b", byp, c, ab2, exp_busy(rt, byp)); end
                if (ast !== exp_stall(byp)) begin bad++; $display("FAIL rnd_stall byp=%0d cyc=%0d got %b want %b", byp, c, ast, exp_stall(byp)); end
                if (apc !== exp_cnt()) begin bad++; $display("FAIL rnd_cnt byp=%0d cyc=%0d got %0d want %0d", byp, c, apc, exp_cnt()); end
            end
            tick();
        end
    endtask

    initial begin
        foreach (m_regs[i]) begin m_regs[i] = 0; m_pend[i] = 0; end
        idle(); rs = 0; rt = 0;
        @(negedge CLK);
        test_reset();
        test_zero();
        test_collision();
        test_scoreboard();
        test_set_clear();
        test_reset_midload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the single-cycle CPU register file. It has two combinational read ports and two independent synchronous write ports. Port A is the ALU/immediate writeback and port B is the load (memory) writeback. It adds same-cycle write-to-read bypass, a hardwired zero register and a per-register pending scoreboard so multi-cycle loads can stall dependent instructions. It sits between decode (rs/rt read, destination issue) and the writeback stage; RegDst/DBDataSrc muxing stays upstream.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read stored value only

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
rs  in  ADDR_W  read address, port 1
rt  in  ADDR_W  read address, port 2
Data1  out  DATA_W  read data for rs (combinational)
Data2  out  DATA_W  read data for rt (combinational)
WreA  in  1  write enable, ALU port
WAddrA  in  ADDR_W  write address, ALU port
WDataA  in  DATA_W  write data, ALU port
WreB  in  1  write enable, load port
WAddrB  in  ADDR_W  write address, load port
WDataB  in  DATA_W  write data, load port
IssueValid  in  1  a load with destination IssueDst is issued this cycle
IssueDst  in  ADDR_W  destination to mark pending
Busy1  out  1  rs pending and not resolved this cycle
Busy2  out  1  rt pending and not resolved this cycle
Stall  out  1  Busy1 | Busy2 | (IssueValid & IssueDst pending & not resolved this cycle)
PendCount  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset is synchronous, active-high: on a rising CLK with Reset=1, all registers become 0, all pending bits become 0 and PendCount becomes 0. Writes and issues in that cycle are ignored. Reset mid-load discards the pending state.
- Writes take effect at the rising edge. There is no read latency: Data1/Data2 follow rs/rt and the array combinationally.
- Write collision: if WreA and WreB target the same address in the same cycle, port B's data is stored and A's is dropped.
- Zero register (ZERO_REG=1): writes to address 0 are discarded on both ports. Reads of address 0 return 0, including under bypass. Issue to 0 sets no pending bit; Busy and Stall never assert for address 0.
- Bypass (BYPASS=1): a read address that matches an active write returns that write's data, with B taking priority over A. With BYPASS=0, reads return the stored value until the next cycle.
- Scoreboard: one pending bit per register.
  - Set: at the edge when IssueValid=1 and IssueDst is non-zero.
  - Clear: at the edge when WreB=1 with WAddrB matching that register.
  - WreA does not clear pending.
  - Set and clear of the same address in the same cycle leaves the bit set (the new issue wins).
  - Issue to an already-pending register leaves the bit set; Stall is raised combinationally that cycle (WAW).
- "Resolved this cycle": WreB=1 and WAddrB equals the queried address. In that case Busy is 0 (the value is forwarded when BYPASS=1). With BYPASS=0, Busy stays 1 on the resolving cycle.
- PendCount is the registered population count of the pending bits. It updates at the same edge as the bits and has a maximum of 2**ADDR_W - 1 when ZERO_REG=1. Simultaneous set of X and clear of Y (X≠Y) leaves the count unchanged.
- Stall is an output only. The block does not gate writes or issues; upstream holds IssueValid low while Stall=1, except for the WAW case, which it must resolve itself.

Test Plan:
- Reset, then rs=0, rt=1 -> Data1=0, Data2=0, PendCount=0. Then WreA=1, WAddrA=2, WDataA=1 for one edge; rs=2 next cycle -> Data1=1.
- WreA=1/WAddrA=0/WDataA=32'hFFFF_FFFF and WreB=1/WAddrB=0 -> address 0 reads 0 in the same cycle and the next; IssueValid with IssueDst=0 -> PendCount stays 0.
- Same cycle WreA→r5=3 and WreB→r5=4 -> Data1 (rs=5) shows 4 combinationally (BYPASS=1) and after the edge. Repeat with BYPASS=0 -> 0 before the edge, 4 after.
- Issue IssueDst=4 -> next cycle rt=4 gives Busy2=1, Stall=1, PendCount=1. Then WreB→r4=7 -> Busy2=0 and Data2=7 in that cycle; after the edge PendCount=0.
- Same edge: IssueValid with IssueDst=6 and WreB→r6 -> r6 stays pending and PendCount increments. Reissue to r6 while pending -> Stall=1 and PendCount unchanged.
- Pending r3 and r9 (PendCount=2), assert Reset for one edge -> all registers 0, PendCount=0, Busy1/Busy2=0 for rs=3, rt=9.
